// File: rtl/freq_gate_controller.sv
// Gated frequency counter sequencer: synchronises signal_in, gates its rising edges
// into a BCD digit chain for GATE_CYCLES clocks, then hands the result over valid/ready.
module freq_gate_controller #(
    parameter int GATE_CYCLES = 1000000,
    parameter int DIGITS      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  signal_in,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  overflow_in,
    output logic                  counter_clear_out,
    output logic                  counter_enable_out,
    output logic                  gate_active_out,
    output logic [4*DIGITS-1:0]   result_digits_out,
    output logic                  result_overflow_out,
    output logic                  result_valid_out,
    input  logic                  result_ready_in
);

    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   history_r;
    logic                   rise_s;
    logic [TW-1:0]          timer_r;
    logic                   sticky_r;

    // Synchroniser chain and edge history; runs in every state so history persists across windows
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            sync_r    <= '0;
            history_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], signal_in};
            history_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s             = sync_r[SYNC_STAGES-1] & ~history_r;
    // All control outputs decode registers only, so no input reaches them combinationally
    assign counter_clear_out  = (state_r == CLEAR);
    assign gate_active_out    = (state_r == GATE);
    assign counter_enable_out = rise_s && (state_r == GATE);

    // State register, gate timer, sticky overflow and result/handshake registers
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_r             <= CLEAR;
            timer_r             <= '0;
            sticky_r            <= 1'b0;
            result_digits_out   <= '0;
            result_overflow_out <= 1'b0;
            result_valid_out    <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                CLEAR: begin
                    timer_r  <= '0;
                    sticky_r <= 1'b0;
                end
                GATE: begin
                    timer_r <= (timer_r == TIMER_LAST) ? '0 : timer_r + TIMER_ONE;
                    if (counter_enable_out && overflow_in) begin
                        sticky_r <= 1'b1;
                    end
                end
                LATCH: begin
                    result_digits_out   <= digits_in;
                    result_overflow_out <= sticky_r;
                    result_valid_out    <= 1'b1;
                end
                WAIT: begin
                    if (result_ready_in) begin
                        result_valid_out <= 1'b0;
                    end
                end
                default: begin
                    timer_r <= '0;
                end
            endcase
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            CLEAR: state_s = GATE;
            GATE: begin
                if (timer_r == TIMER_LAST) begin
                    state_s = LATCH;
                end else begin
                    state_s = GATE;
                end
            end
            LATCH: state_s = WAIT;
            WAIT: begin
                if (result_valid_out && result_ready_in) begin
                    state_s = CLEAR;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = CLEAR;
        endcase
    end

endmodule

// File: tb/tb_freq_gate_controller.sv
// Directed bench for freq_gate_controller with a behavioural 2-digit BCD chain.
module tb_freq_gate_controller;

    localparam int GATE_CYCLES = 20;
    localparam int DIGITS      = 2;
    localparam int SYNC_STAGES = 2;

    logic       clk;
    logic       reset_n;
    logic       signal_in;
    logic       ready;
    logic       clear;
    logic       enable;
    logic       gate;
    logic [7:0] res_d;
    logic       res_o;
    logic       valid;
    logic [7:0] chain_r = 8'h00;
    logic       chain_ovf;
    logic       preload_req;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_d;
    logic       prev_o;

    freq_gate_controller #(
        .GATE_CYCLES(GATE_CYCLES),
        .DIGITS(DIGITS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_in(clk),
        .reset_n_in(reset_n),
        .signal_in(signal_in),
        .digits_in(chain_r),
        .overflow_in(chain_ovf),
        .counter_clear_out(clear),
        .counter_enable_out(enable),
        .gate_active_out(gate),
        .result_digits_out(res_d),
        .result_overflow_out(res_o),
        .result_valid_out(valid),
        .result_ready_in(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Behavioural BCD chain: clear beats preload beats count
    always_ff @(posedge clk) begin
        if (clear) chain_r <= 8'h00;
        else if (preload_req) chain_r <= 8'h98;
        else if (enable) chain_r <= bcd_inc(chain_r);
    end
    assign chain_ovf = enable && (chain_r == 8'h99);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic bit_at(input logic [20:0] m, input int c);
        logic [20:0] sh;
        if (c < 0 || c > 20) return 1'b0;
        sh = m >> c;
        return sh[0];
    endfunction

    // One window starting at the CLEAR cycle (c=0): GATE is c=1..20, LATCH c=21, WAIT c>=22.
    // A mask bit at c starts a 2-cycle high pulse whose rise appears in cycle c+2.
    task automatic run_window(input string nm, input logic [20:0] mask, input bit preload,
                              input logic [7:0] exp_d, input bit exp_o, input int hold);
        ready = (hold == 0);
        for (int c = 0; c <= 21; c++) begin
            signal_in   = bit_at(mask, c) | bit_at(mask, c - 1);
            preload_req = preload && (c == 1);
            chk({nm, "_clear"}, 32'(clear), 32'(c == 0));
            chk({nm, "_gate"}, 32'(gate), 32'(c >= 1 && c <= 20));
            chk({nm, "_enable"}, 32'(enable), 32'((c >= 1 && c <= 20) && bit_at(mask, c - 2)));
            chk({nm, "_valid_low"}, 32'(valid), 32'd0);
            chk({nm, "_hold_digits"}, 32'(res_d), 32'(prev_d));
            chk({nm, "_hold_ovf"}, 32'(res_o), 32'(prev_o));
            tick();
        end
        preload_req = 1'b0;
        for (int k = 0; k < hold; k++) begin
            signal_in = ((k % 4) < 2);
            chk({nm, "_wait_valid"}, 32'(valid), 32'd1);
            chk({nm, "_wait_digits"}, 32'(res_d), 32'(exp_d));
            chk({nm, "_wait_ovf"}, 32'(res_o), 32'(exp_o));
            chk({nm, "_wait_clear"}, 32'(clear), 32'd0);
            chk({nm, "_wait_enable"}, 32'(enable | gate), 32'd0);
            tick();
        end
        ready     = 1'b1;
        signal_in = 1'b0;
        chk({nm, "_valid"}, 32'(valid), 32'd1);
        chk({nm, "_digits"}, 32'(res_d), 32'(exp_d));
        chk({nm, "_ovf"}, 32'(res_o), 32'(exp_o));
        chk({nm, "_last_wait"}, 32'({clear, gate, enable}), 32'd0);
        tick();
        prev_d = exp_d;
        prev_o = exp_o;
    endtask

    typedef struct {
        string      name;
        logic [20:0] mask;
        bit         preload;
        logic [7:0] exp_d;
        bit         exp_o;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int en_seen;
        vecs[0] = '{"idle",        21'h000000, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{"period4",     21'h011111, 1'b0, 8'h05, 1'b0};
        vecs[2] = '{"last_gate",   21'h040000, 1'b0, 8'h01, 1'b0};
        vecs[3] = '{"latch_edge",  21'h080000, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{"after_latch", 21'h000004, 1'b0, 8'h01, 1'b0};
        vecs[5] = '{"wait_edge",   21'h100000, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{"mixed",       21'h004221, 1'b0, 8'h04, 1'b0};
        vecs[7] = '{"preload98",   21'h000444, 1'b1, 8'h01, 1'b1};
        vecs[8] = '{"ovf_clears",  21'h000000, 1'b0, 8'h00, 1'b0};

        reset_n     = 1'b0;
        signal_in   = 1'b0;
        ready       = 1'b1;
        preload_req = 1'b0;
        prev_d      = 8'h00;
        prev_o      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_clear", 32'(clear), 32'd1);
            chk("reset_enable", 32'(enable), 32'd0);
            chk("reset_gate", 32'(gate), 32'd0);
            chk("reset_valid", 32'(valid), 32'd0);
        end
        reset_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            run_window(vecs[v].name, vecs[v].mask, vecs[v].preload, vecs[v].exp_d, vecs[v].exp_o, 0);
        end

        run_window("ready_low", 21'h000008, 1'b0, 8'h01, 1'b0, 10);

        // Abandon a window mid-GATE after four counted rises
        en_seen = 0;
        for (int c = 0; c < 16; c++) begin
            signal_in = bit_at(21'h001111, c) | bit_at(21'h001111, c - 1);
            if (enable) en_seen++;
            tick();
        end
        chk("mid_gate_open", 32'(gate), 32'd1);
        chk("mid_enables", 32'(en_seen), 32'd4);
        reset_n   = 1'b0;
        signal_in = 1'b0;
        tick();
        chk("mid_reset_clear", 32'(clear), 32'd1);
        chk("mid_reset_valid", 32'(valid), 32'd0);
        chk("mid_reset_gate", 32'(gate | enable), 32'd0);
        chk("mid_reset_digits", 32'(res_d), 32'd0);
        reset_n = 1'b1;
        prev_d  = 8'h00;
        prev_o  = 1'b0;
        run_window("after_reset", 21'h000220, 1'b0, 8'h02, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
